// File: rtl/if_prefetch.sv
// Instruction-fetch prefetcher: keeps a small queue of fetched {inst, pc} pairs
// ahead of decode, issuing one memory read per cycle while there is room for the reply.
module if_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        IM_enable,
  output logic [31:0] IM_address,
  input  logic [31:0] IM_out,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);
  localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic         push;
  logic         pop;
  logic [CNT_W:0] occ;

  // Occupancy counts the reply still on its way back, so a reply always has a slot.
  assign occ       = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign if_valid  = (count_q != '0);
  assign pop       = if_valid && id_ready && !redirect;
  assign push      = inflight_q && !redirect;
  assign IM_enable = rst && !redirect &&
                     ((occ < DEPTH_OCC) || ((occ == DEPTH_OCC) && pop));
  assign IM_address = fetch_pc_q & 32'hFFFF_FFFC;
  assign if_inst    = if_valid ? inst_mem[head_q] : 32'h0;
  assign if_pc      = if_valid ? pc_mem[head_q]   : 32'h0;

  // NOTE: every signal gets its default at the top of always_comb, so no path leaves it unassigned (no latch).
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (IM_enable) begin
        fetch_pc_d    = fetch_pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC_A;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // NOTE: queue storage has no reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail_q] <= IM_out;
      pc_mem[tail_q]   <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: cycle-exact vector table, directed corner
// sequences, and a randomized run against a request-queue reference model.
module tb_if_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        IM_enable;
  logic [31:0] IM_address;
  logic [31:0] IM_out = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .IM_enable  (IM_enable),
    .IM_address (IM_address),
    .IM_out     (IM_out),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_ready   (id_ready),
    .if_valid   (if_valid),
    .if_inst    (if_inst),
    .if_pc      (if_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Instruction memory: word for the requested address one cycle later, junk otherwise.
  always @(posedge clk) begin
    if (IM_enable) IM_out <= word_of(IM_address);
    else           IM_out <= $urandom;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [31:0] addr,
                         input logic valid, input logic [31:0] pc);
    check({tag, ".IM_enable"},  {31'h0, IM_enable}, {31'h0, en});
    check({tag, ".IM_address"}, IM_address, addr);
    check({tag, ".if_valid"},   {31'h0, if_valid}, {31'h0, valid});
    check({tag, ".if_pc"},      if_pc, valid ? pc : 32'h0);
    check({tag, ".if_inst"},    if_inst, valid ? word_of(pc) : 32'h0);
  endtask

  task automatic set_in(input logic rd, input logic [31:0] rpc, input logic ir);
    redirect    = rd;
    redirect_pc = rpc;
    id_ready    = ir;
  endtask

  // Drops reset in the low phase, checks asynchronous reset values, releases at the next negedge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    set_in(1'b0, 32'h0, 1'b0);
    #1;
    chk_out("reset", 1'b0, RESET_PC, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic        rst_before;
    logic        id_ready;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic rb, input logic ir, input logic en,
                              input logic [31:0] addr, input logic valid, input logic [31:0] pc);
    vec_t v;
    v.rst_before = rb; v.id_ready = ir; v.en = en;
    v.addr = addr; v.valid = valid; v.pc = pc;
    return v;
  endfunction

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } req_t;

  vec_t vecs[$];

  initial begin
    // Streaming from reset with decode always ready.
    vecs.push_back(mk(1, 1, 1, 32'd0,  0, 32'd0));
    vecs.push_back(mk(0, 1, 1, 32'd4,  0, 32'd0));
    vecs.push_back(mk(0, 1, 1, 32'd8,  1, 32'd0));
    vecs.push_back(mk(0, 1, 1, 32'd12, 1, 32'd4));
    vecs.push_back(mk(0, 1, 1, 32'd16, 1, 32'd8));
    // Decode stalled from reset: fill to DEPTH, hold, then drain without gaps.
    vecs.push_back(mk(1, 0, 1, 32'd0,  0, 32'd0));
    vecs.push_back(mk(0, 0, 1, 32'd4,  0, 32'd0));
    vecs.push_back(mk(0, 0, 1, 32'd8,  1, 32'd0));
    vecs.push_back(mk(0, 0, 1, 32'd12, 1, 32'd0));
    vecs.push_back(mk(0, 0, 0, 32'd16, 1, 32'd0));
    vecs.push_back(mk(0, 0, 0, 32'd16, 1, 32'd0));
    vecs.push_back(mk(0, 1, 1, 32'd16, 1, 32'd0));
    vecs.push_back(mk(0, 1, 1, 32'd20, 1, 32'd4));
    vecs.push_back(mk(0, 1, 1, 32'd24, 1, 32'd8));
    vecs.push_back(mk(0, 1, 1, 32'd28, 1, 32'd12));
    vecs.push_back(mk(0, 1, 1, 32'd32, 1, 32'd16));
    vecs.push_back(mk(0, 1, 1, 32'd36, 1, 32'd20));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) do_reset();
      set_in(1'b0, 32'h0, vecs[i].id_ready);
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].addr, vecs[i].valid, vecs[i].pc);
      @(negedge clk);
    end

    // Redirect with three entries queued and one reply in flight, then a held redirect.
    do_reset();
    for (int i = 0; i < 4; i++) @(negedge clk);
    set_in(1'b1, 32'h0000_0103, 1'b0);
    #1;
    chk_out("redir_cyc", 1'b0, 32'd16, 1'b1, 32'd0);
    @(negedge clk);
    set_in(1'b0, 32'h0, 1'b1);
    #1;
    chk_out("redir_after", 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk_out("redir_wait", 1'b1, 32'h0000_0104, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk_out("redir_first", 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100);
    @(negedge clk);
    set_in(1'b1, 32'h0000_2000, 1'b1);
    @(negedge clk);
    set_in(1'b1, 32'h0000_3006, 1'b1);
    #1;
    chk_out("redir_held", 1'b0, 32'h0000_2000, 1'b0, 32'h0);
    @(negedge clk);
    set_in(1'b0, 32'h0, 1'b1);
    #1;
    chk_out("redir_latest", 1'b1, 32'h0000_3004, 1'b0, 32'h0);

    // Address wrap at the top of the 32-bit space.
    @(negedge clk);
    set_in(1'b1, 32'hFFFF_FFF8, 1'b1);
    @(negedge clk);
    set_in(1'b0, 32'h0, 1'b1);
    #1;
    chk_out("wrap0", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk_out("wrap1", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk_out("wrap2", 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8);
    @(negedge clk);
    #1;
    chk_out("wrap3", 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    chk_out("wrap4", 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000);

    // Asynchronous reset mid-stream, then restart from RESET_PC.
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, RESET_PC, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_out("post_rst0", 1'b1, RESET_PC, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk_out("post_rst1", 1'b1, RESET_PC + 32'd4, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk_out("post_rst2", 1'b1, RESET_PC + 32'd8, 1'b1, RESET_PC);

    // Randomized run against a request-queue model: every issued address is
    // delivered in order two or more cycles later unless a redirect flushes it.
    begin
      req_t        q[$];
      logic [31:0] exp_fetch;
      logic        exp_valid, exp_pop, exp_en, rd, ir;
      logic [31:0] rpc;
      int          delivered;
      do_reset();
      exp_fetch = RESET_PC;
      delivered = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
        rd  = ($urandom_range(0, 99) < 3);
        rpc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
        ir  = $urandom_range(0, 1) == 1;
        set_in(rd, rpc, ir);
        #1;
        exp_valid = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
        exp_pop   = exp_valid && ir && !rd;
        exp_en    = !rd && ((q.size() < DEPTH) || ((q.size() == DEPTH) && exp_pop));
        chk_out("rand", exp_en, exp_fetch, exp_valid, exp_valid ? q[0].pc : 32'h0);
        if (rd) begin
          q.delete();
          exp_fetch = rpc & 32'hFFFF_FFFC;
        end else begin
          if (exp_pop) begin
            void'(q.pop_front());
            delivered++;
          end
          if (exp_en) begin
            q.push_back('{pc: exp_fetch, cyc: cyc});
            exp_fetch = exp_fetch + 32'd4;
          end
        end
        @(negedge clk);
      end
      check("rand_progress", {31'h0, (delivered > 2000)}, 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter: DEPTH, 4, number of instruction queue entries (power of two, 2..16).
REQ-002 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-005 Port: IM_enable  output  1  instruction memory read request this cycle.
REQ-006 Port: IM_address  output  32  byte address of the request; bits [1:0] always 0.
REQ-007 Port: IM_out  input  32  instruction word; valid exactly one cycle after the cycle IM_enable=1.
REQ-008 Port: redirect  input  1  branch/jump taken; flush and restart fetch.
REQ-009 Port: redirect_pc  input  32  restart address; bits [1:0] ignored and treated as 0.
REQ-010 Port: id_ready  input  1  decode stage accepts the head instruction this cycle.
REQ-011 Port: if_valid  output  1  if_inst/if_pc hold a valid instruction.
REQ-012 Port: if_inst  output  32  head instruction word.
REQ-013 Port: if_pc  output  32  byte address of if_inst.

Function
REQ-014 State: fetch_pc (32), inflight (1), inflight_pc (32), FIFO of DEPTH {inst, pc} entries, count (0..DEPTH).
REQ-015 IM_enable = rst && !redirect && (count + inflight < DEPTH), or (count + inflight = DEPTH with a pop this cycle); IM_address = fetch_pc.
REQ-016 On an edge with IM_enable=1: fetch_pc <= fetch_pc + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); inflight <= 1; inflight_pc <= fetch_pc; else inflight <= 0.
REQ-017 On an edge with inflight=1 and redirect=0: push {IM_out, inflight_pc} at tail.
REQ-018 Pop occurs when if_valid && id_ready && !redirect; head advances by one.
REQ-019 Simultaneous push and pop: count unchanged, both performed; push into a full queue never occurs (guaranteed by REQ-015).
REQ-020 if_valid = (count != 0); if_inst/if_pc = head entry; when count=0, if_inst=0 and if_pc=0.
REQ-021 Issue-to-present latency: instruction requested in cycle N appears on if_valid/if_inst in cycle N+2 if the queue was empty.
REQ-022 Steady state with id_ready=1 held: one instruction delivered per cycle, sequential pcs, no bubbles after the first.
REQ-023 redirect=1 on an edge: count <= 0, queue discarded, inflight response dropped, inflight <= 0, fetch_pc <= {redirect_pc[31:2], 2'b00}; no pop, no push, no issue that cycle.
REQ-024 First request after redirect issued the cycle following redirect; redirect held multiple cycles re-flushes each cycle with the latest redirect_pc.
REQ-025 id_ready=0: queue fills to DEPTH then IM_enable=0; no instruction lost or duplicated.
REQ-026 if_inst/if_pc stable while if_valid=1 and id_ready=0.

Reset
REQ-027 While rst=0 (asynchronous, immediate): fetch_pc=RESET_PC, inflight=0, count=0, IM_enable=0, IM_address=RESET_PC, if_valid=0, if_inst=0, if_pc=0.
REQ-028 Reset asserted mid-operation discards queue and inflight response; first request after release goes to RESET_PC in the first cycle with rst=1.

Verification
REQ-029 Reset release, id_ready=1, IM returns addr-derived words -> IM_address 0,4,8,...; if_valid rises 2 cycles after first IM_enable; if_pc 0,4,8 on consecutive cycles.
REQ-030 id_ready=0 from reset, DEPTH=4 -> exactly 4 instructions (pc 0..12) buffered, IM_enable=0 thereafter, if_pc=0 held; raise id_ready -> pcs 0,4,8,12,16 delivered in order, no gaps after refill.
REQ-031 redirect=1 with redirect_pc=32'h0000_0103 while queue holds 3 entries and one inflight -> next cycle if_valid=0, IM_address=32'h0000_0100; first delivered if_pc=32'h0000_0100, no stale pc ever appears.
REQ-032 Redirect to 32'hFFFF_FFF8 -> requests FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004 in order.
REQ-033 rst driven low mid-stream between clock edges -> outputs reach reset values without a clock edge; after release, first IM_address=RESET_PC.
REQ-034 Random id_ready (50%) and random redirects over 10000 cycles -> delivered pc sequence matches reference model (sequential from each redirect target), count never exceeds DEPTH.
